onehot_enable_seq: RTL and testbench



---
 rtl/onehot_seq_pkg.sv | 27 ++
 rtl/onehot_enable_seq_dec.sv | 27 ++
 rtl/onehot_enable_seq.sv | 171 +++++++++++++++++
 tb/tb_onehot_enable_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/onehot_seq_pkg.sv
// Shared types and encodings for the one-hot enable sequencer.
// Mode/state enums plus a small legality helper.
package onehot_seq_pkg;

  localparam logic [1:0] MODE_ENC_PULSE = 2'b00;
  localparam logic [1:0] MODE_ENC_HOLD  = 2'b01;
  localparam logic [1:0] MODE_ENC_SWEEP = 2'b10;
  localparam logic [1:0] MODE_ENC_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    MODE_PULSE = MODE_ENC_PULSE,
    MODE_HOLD  = MODE_ENC_HOLD,
    MODE_SWEEP = MODE_ENC_SWEEP,
    MODE_RSVD  = MODE_ENC_RSVD
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_SWEEP  = 2'b10
  } state_e;

  function automatic logic mode_is_legal(input logic [1:0] mode);
    return (mode != MODE_ENC_RSVD);
  endfunction

endpackage

// File: rtl/onehot_enable_seq_dec.sv
// Combinational channel-index to one-hot decoder with range flag.
// Indices at or above N_OUT decode to all-zero and clear o_in_range.
module onehot_dec #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned N_OUT = 16
) (
  input  logic [SEL_W-1:0] i_sel,
  output logic [N_OUT-1:0] o_dec,
  output logic             o_in_range
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);

  // Decode and range check
  always_comb begin
    o_dec = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_dec[i] = 1'b1;
      end else begin
        o_dec[i] = 1'b0;
      end
    end
    o_in_range = ({1'b0, i_sel} < N_LIM);
  end

endmodule

// File: rtl/onehot_enable_seq.sv
// Registered one-hot enable sequencer: PULSE, HOLD and wrap-around SWEEP
// driven over a valid/ready request port, with reject, done and abort.
module onehot_enable_seq
  import onehot_seq_pkg::*;
#(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned N_OUT = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [1:0]       in_mode,
  input  logic [LEN_W-1:0] in_len,
  input  logic             abort,
  output logic [N_OUT-1:0] en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [SEL_W:0]   N_LIM   = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_OUT - 1);

  state_e           r_state;
  logic [SEL_W-1:0] r_ch;
  logic [SEL_W-1:0] r_last;
  logic [LEN_W-1:0] r_cnt;
  logic             r_done;
  logic             r_err;

  state_e           w_state_nxt;
  logic [SEL_W-1:0] w_ch_nxt;
  logic [SEL_W-1:0] w_last_nxt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;

  logic             w_accept;
  logic             w_abort_act;
  logic             w_req_bad;
  logic [LEN_W-1:0] w_len_eff;
  logic [SEL_W-1:0] w_sweep_last;
  logic [SEL_W-1:0] w_ch_inc;
  logic [N_OUT-1:0] w_dec;
  logic             w_in_range;

  onehot_dec #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_dec (
    .i_sel      (r_ch),
    .o_dec      (w_dec),
    .o_in_range (w_in_range)
  );

  // A request arriving together with abort is always dropped.
  assign in_ready    = (r_state == ST_IDLE) | r_done;
  assign w_accept    = in_valid & in_ready & ~abort;
  assign w_abort_act = abort & (r_state != ST_IDLE);
  assign w_req_bad   = ({1'b0, in_sel} >= N_LIM) | ~mode_is_legal(in_mode);
  assign w_len_eff   = (in_len == '0) ? LEN_W'(1) : in_len;
  assign w_sweep_last = (in_sel == '0) ? LAST_CH : (in_sel - SEL_W'(1));
  assign w_ch_inc    = (r_ch == LAST_CH) ? '0 : (r_ch + SEL_W'(1));

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

  // Enable is decoded only from registered state; idle forces all-zero
  always_comb begin
    if ((r_state != ST_IDLE) && w_in_range) begin
      en = w_dec;
    end else begin
      en = '0;
    end
  end

  // Next-state, counter and flag computation
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_abort_act) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      if (w_req_bad) begin
        // Accept only happens in idle or in the final cycle, so both end idle
        w_err_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_ch_nxt = in_sel;
        case (mode_e'(in_mode))
          MODE_PULSE: begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end
          MODE_HOLD: begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = w_len_eff - LEN_W'(1);
            w_done_nxt  = (w_len_eff == LEN_W'(1));
          end
          MODE_SWEEP: begin
            w_state_nxt = ST_SWEEP;
            w_last_nxt  = w_sweep_last;
            w_cnt_nxt   = '0;
            w_done_nxt  = (in_sel == w_sweep_last);
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
          end
        endcase
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_ACTIVE: begin
          if (r_done) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt  = r_cnt - LEN_W'(1);
            w_done_nxt = (r_cnt == LEN_W'(1));
          end
        end
        ST_SWEEP: begin
          if (r_done) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_ch_nxt   = w_ch_inc;
            w_done_nxt = (w_ch_inc == r_last);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ch    <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_onehot_enable_seq.sv
// Randomized + directed bench for onehot_enable_seq, two instances
// (N_OUT=16 and N_OUT=10) checked against a queue-based schedule model.
module tb_onehot_enable_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_sel;
  logic [1:0]  in_mode;
  logic [7:0]  in_len;
  logic        abort;

  logic        rdy0, busy0, done0, err0;
  logic [15:0] en0;
  logic        rdy1, busy1, done1, err1;
  logic [9:0]  en1;

  int n_total = 0;
  int n_bad   = 0;

  // Per instance: one entry per future enable cycle, value = channel*2 + is_last
  int mq [2][$];
  bit err_exp [2];

  always #5 clk = ~clk;

  onehot_enable_seq #(.SEL_W(4), .N_OUT(16), .LEN_W(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_sel(in_sel),
    .in_mode(in_mode), .in_len(in_len), .abort(abort), .en(en0), .busy(busy0),
    .done(done0), .err(err0)
  );

  onehot_enable_seq #(.SEL_W(4), .N_OUT(10), .LEN_W(8)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_sel(in_sel),
    .in_mode(in_mode), .in_len(in_len), .abort(abort), .en(en1), .busy(busy1),
    .done(done1), .err(err1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step_model(input int m);
    int n;
    int l;
    bit acc;
    n = (m == 0) ? 16 : 10;
    acc = in_valid && (mq[m].size() <= 1) && !abort;
    if (mq[m].size() > 0) void'(mq[m].pop_front());
    if (abort) mq[m].delete();
    err_exp[m] = 1'b0;
    if (acc) begin
      if ((int'(in_sel) >= n) || (in_mode == 2'b11)) begin
        err_exp[m] = 1'b1;
      end else if (in_mode == 2'b00) begin
        mq[m].push_back(int'(in_sel) * 2 + 1);
      end else if (in_mode == 2'b01) begin
        l = (in_len == 8'd0) ? 1 : int'(in_len);
        for (int i = 0; i < l; i++) mq[m].push_back(int'(in_sel) * 2 + ((i == l - 1) ? 1 : 0));
      end else begin
        for (int i = 0; i < n; i++) mq[m].push_back(((int'(in_sel) + i) % n) * 2 + ((i == n - 1) ? 1 : 0));
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ge, xe;
    logic gd, gb, gr, xd, xb;
    for (int m = 0; m < 2; m++) begin
      ge = (m == 0) ? 32'(en0) : 32'(en1);
      gd = (m == 0) ? done0 : done1;
      gb = (m == 0) ? busy0 : busy1;
      gr = (m == 0) ? err0 : err1;
      if (mq[m].size() > 0) begin
        xe = 32'd1 << (mq[m][0] >> 1);
        xd = (mq[m][0] % 2) == 1;
        xb = 1'b1;
      end else begin
        xe = 32'd0;
        xd = 1'b0;
        xb = 1'b0;
      end
      check_val($sformatf("en_n%0d", m), ge, xe);
      check_val($sformatf("done_n%0d", m), 32'(gd), 32'(xd));
      check_val($sformatf("busy_n%0d", m), 32'(gb), 32'(xb));
      check_val($sformatf("err_n%0d", m), 32'(gr), 32'(err_exp[m]));
    end
  endtask

  task automatic do_cycle();
    check_val("rdy_n0", 32'(rdy0), 32'(mq[0].size() <= 1));
    check_val("rdy_n1", 32'(rdy1), 32'(mq[1].size() <= 1));
    step_model(0);
    step_model(1);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input int sel, input int mode, input int len, input bit ab);
    in_valid = v;
    in_sel   = 4'(sel);
    in_mode  = 2'(mode);
    in_len   = 8'(len);
    abort    = ab;
  endtask

  task automatic req(input int sel, input int mode, input int len);
    drive(1'b1, sel, mode, len, 1'b0);
    do_cycle();
    drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // PULSE sel=3
    req(3, 0, 0);
    check_val("pulse_en", 32'(en0), 32'h0008);
    check_val("pulse_done", 32'(done0), 32'd1);
    idle(2);

    // HOLD sel=15 len=5 (illegal on the 10-output instance), then len=0
    req(15, 1, 5);
    idle(6);
    req(15, 1, 0);
    idle(2);

    // SWEEP sel=14 and sel=8
    req(14, 2, 0);
    idle(17);
    req(8, 2, 0);
    check_val("sweep10_first", 32'(en1), 32'h100);
    idle(17);

    // Illegal index / reserved mode
    req(12, 0, 0);
    idle(1);
    req(2, 3, 0);
    check_val("rsvd_err", 32'(err0), 32'd1);
    idle(2);

    // Back-to-back: PULSE accepted in the HOLD done cycle
    req(2, 1, 3);
    idle(2);
    check_val("b2b_done", 32'(done0), 32'd1);
    req(1, 0, 0);
    check_val("b2b_en", 32'(en0), 32'h0002);
    idle(2);

    // HOLD len=20 aborted on its fourth enable cycle
    req(4, 1, 20);
    idle(3);
    drive(1'b0, 0, 0, 0, 1'b1);
    do_cycle();
    check_val("abort_en", 32'(en0), 32'd0);
    idle(2);

    // Reset mid-SWEEP clears en immediately
    req(8, 2, 0);
    idle(4);
    #3;
    rst = 1'b1;
    #1;
    check_val("rst_en_n0", 32'(en0), 32'd0);
    check_val("rst_en_n1", 32'(en1), 32'd0);
    mq[0].delete();
    mq[1].delete();
    err_exp[0] = 1'b0;
    err_exp[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 3),
            $urandom_range(0, 6), $urandom_range(0, 15) == 0);
      do_cycle();
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
